// File: rtl/bcd_scan_display_pkg.sv
// Segment patterns shared by the scanned BCD display and its decoder.
// Patterns are {g,f,e,d,c,b,a}, active-low.
package bcd_scan_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_scan_display_seg.sv
// 4-bit code to 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg
  import bcd_scan_display_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  // Pure lookup, no state.
  always_comb begin
    seg_o = SEG_DASH;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed BCD display driver: captures a converter result on the rising
// edge of ready and scans one digit per refresh slot with optional
// leading-zero blanking.
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int nDigits    = 4,
  parameter int refreshDiv = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ready,
  input  logic [nDigits*4-1:0] bcd,
  input  logic                 blank_lz,
  output logic [6:0]           seg,
  output logic [nDigits-1:0]   an
);

  localparam int PW = $clog2(refreshDiv);
  localparam int IW = (nDigits > 1) ? $clog2(nDigits) : 1;

  logic                 ready_q, ready_d;
  logic [nDigits*4-1:0] shadow_q, shadow_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [6:0]           seg_q, seg_d;
  logic [nDigits-1:0]   an_q, an_d;

  logic                 capture;
  logic                 tick;
  logic [IW-1:0]        idx_nxt;
  logic [3:0]           sel_code;
  logic                 upper_zero;
  logic                 blank;
  logic [nDigits-1:0]   an_new;
  logic [6:0]           dec_seg;

  bcd_to_seg u_dec (
    .code_i (sel_code),
    .seg_o  (dec_seg)
  );

  // Next-state: capture, prescaler, scan index and the registered drive.
  // Decode always reads shadow_q, so a capture on a tick edge shows the
  // previous value for that one slot.
  always_comb begin
    ready_d    = ready;
    capture    = ready && !ready_q;
    shadow_d   = capture ? bcd : shadow_q;

    tick       = (presc_q == PW'(refreshDiv - 1));
    presc_d    = tick ? '0 : presc_q + 1'b1;

    idx_nxt    = (idx_q == IW'(nDigits - 1)) ? '0 : idx_q + 1'b1;
    idx_d      = tick ? idx_nxt : idx_q;

    sel_code   = 4'd0;
    upper_zero = 1'b1;
    an_new     = '1;
    for (int k = 0; k < nDigits; k++) begin
      if (k == int'(idx_nxt)) begin
        sel_code  = shadow_q[4*k +: 4];
        an_new[k] = 1'b0;
      end
      if (k >= int'(idx_nxt) && shadow_q[4*k +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
    end
    blank = blank_lz && (idx_nxt != '0) && upper_zero;
    if (blank) begin
      an_new = '1;
    end

    seg_d = seg_q;
    an_d  = an_q;
    if (tick) begin
      seg_d = blank ? SEG_BLANK : dec_seg;
      an_d  = an_new;
    end
  end

  // State registers; reset blanks the display without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q  <= 1'b1;
      shadow_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
    end else begin
      ready_q  <= ready_d;
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized scoreboard bench for bcd_scan_display (4 digits, 4-cycle slots).
module tb_bcd_scan_display;

  localparam int N  = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ready = 1'b1;
  logic [15:0]   bcd = 16'h1234;
  logic          blank_lz = 1'b0;
  logic [6:0]    seg;
  logic [N-1:0]  an;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]   seg;
    logic [N-1:0] an;
    int           cyc;
  } exp_t;
  exp_t q[$];

  // Reference model state: time since reset release and the captured value.
  int          m_cnt;
  logic        m_ready_prev;
  logic [15:0] m_shadow;
  logic [6:0]  m_seg;
  logic [N-1:0] m_an;
  int          m_slot_idx;
  int          m_code;

  bcd_scan_display #(.nDigits(N), .refreshDiv(RD)) dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .bcd      (bcd),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int code);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (code > 9) return 7'h3F;
    return tbl[code];
  endfunction

  task automatic model_reset();
    m_cnt        = 0;
    m_ready_prev = 1'b1;
    m_shadow     = '0;
    m_seg        = 7'h7F;
    m_an         = '1;
    q.delete();
  endtask

  // Model: the j-th slot boundary after reset shows digit j mod N.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        if (m_cnt % RD == RD - 1) begin
          m_slot_idx = (m_cnt / RD + 1) % N;
          m_code     = int'((m_shadow >> (4 * m_slot_idx)) & 16'hF);
          if (blank_lz && m_slot_idx > 0 && (m_shadow >> (4 * m_slot_idx)) == 16'd0) begin
            m_seg = 7'h7F;
            m_an  = '1;
          end else begin
            m_seg = seg_of(m_code);
            m_an  = ~(N'(1) << m_slot_idx);
          end
        end
        if (ready && !m_ready_prev) m_shadow = bcd;
        m_ready_prev = ready;
        q.push_back('{m_seg, m_an, m_cnt});
        m_cnt++;
      end
    end
  end

  // Monitor: the display is presented every cycle; compare each expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (seg !== e.seg || an !== e.an) begin
          errors++;
          $display("FAIL display cyc=%0d: got seg=%h an=%h, want seg=%h an=%h",
                   e.cyc, seg, an, e.seg, e.an);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bcd = 16'($urandom);
    end
  endtask

  task automatic check_async_blank(input string name);
    checks++;
    if (seg !== 7'h7F || an !== '1) begin
      errors++;
      $display("FAIL %s: got seg=%h an=%h, want seg=7f an=%h", name, seg, an, {N{1'b1}});
    end
  endtask

  task automatic capture(input logic [15:0] val, input logic blz, input int hold);
    @(negedge clk);
    ready = 1'b0;
    cycles(2);
    ready    = 1'b1;
    bcd      = val;
    blank_lz = blz;
    cycles(hold);
  endtask

  initial begin
    int nz;
    logic [15:0] v;
    int guard;

    #2 rst = 1'b1;
    #1 check_async_blank("reset_initial");
    repeat (3) @(negedge clk);
    bcd = 16'h1234;
    ready = 1'b1;
    rst = 1'b0;
    repeat (4 * N * RD) @(negedge clk);

    capture(16'h1234, 1'b0, 2 * N * RD + 2);
    capture(16'h0007, 1'b1, 2 * N * RD + 2);
    capture(16'h0000, 1'b1, 2 * N * RD + 2);
    capture(16'h00A5, 1'b0, 2 * N * RD + 2);
    capture(16'h00A5, 1'b1, 2 * N * RD + 2);

    for (int i = 0; i < 30; i++) begin
      nz = $urandom_range(0, 4);
      v  = 16'($urandom);
      if (nz < 4) v = v & 16'((32'd1 << (4 * nz)) - 1);
      capture(v, 1'($urandom), $urandom_range(1, 6));
      for (int j = 0; j < 4; j++) begin
        blank_lz = 1'($urandom);
        cycles($urandom_range(1, 2 * RD));
      end
    end

    // Capture on the same edge as a slot boundary, then reset mid-slot.
    @(negedge clk);
    ready = 1'b0;
    cycles(2);
    guard = 0;
    while (m_cnt % RD != RD - 1 && guard < 2 * RD) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (m_cnt % RD != RD - 1) begin
      errors++;
      $display("FAIL tick_align: got phase=%0d want %0d", m_cnt % RD, RD - 1);
    end
    bcd   = 16'h9876;
    ready = 1'b1;
    cycles(N * RD + 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_async_blank("reset_midslot");
    repeat (2) @(negedge clk);
    ready = 1'b0;
    rst   = 1'b0;
    cycles(3);
    capture(16'h4321, 1'b0, 3 * N * RD);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
